// File: rtl/polar_llr_input_stage_if.sv
// AXI-Stream LLR input, LLR RAM write port and frame status of the polar decoder input stage.
// master = upstream/controller side, slave = the input stage itself.
interface polar_llr_input_stage_if #(
   parameter int LLR_WIDTH  = 8,
   parameter int BUS_LLRS   = 4,
   parameter int ADDR_WIDTH = 8
);
   logic                            input_en;
   logic [LLR_WIDTH*BUS_LLRS-1:0]   saxi_tdata;
   logic                            saxi_tvalid;
   logic                            saxi_tlast;
   logic                            saxi_tready;
   logic                            llr_wr_en;
   logic [ADDR_WIDTH-1:0]           llr_wr_addr;
   logic [LLR_WIDTH*BUS_LLRS-1:0]   llr_wr_data;
   logic                            frame_done;
   logic                            frame_len_err;
   logic [ADDR_WIDTH:0]             beat_count;

   modport master (
      output input_en, saxi_tdata, saxi_tvalid, saxi_tlast,
      input  saxi_tready, llr_wr_en, llr_wr_addr, llr_wr_data,
             frame_done, frame_len_err, beat_count
   );

   modport slave (
      input  input_en, saxi_tdata, saxi_tvalid, saxi_tlast,
      output saxi_tready, llr_wr_en, llr_wr_addr, llr_wr_data,
             frame_done, frame_len_err, beat_count
   );
endinterface

// File: rtl/polar_llr_input_stage.sv
// Polar decoder LLR input stage: AXIS beats -> LLR RAM words, frame length policing, 1-cycle write latency.
// Optional POLAR_LLR_CLIP_EN clips the most negative LLR to its symmetric counterpart before writing.
module polar_llr_input_stage #(
   parameter int N         = 1024,
   parameter int LLR_WIDTH = 8,
   parameter int BUS_LLRS  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   polar_llr_input_stage_if.slave   bus
);
   localparam int WORDS      = N / BUS_LLRS;
   localparam int ADDR_WIDTH = $clog2(WORDS);
   localparam int DW         = LLR_WIDTH * BUS_LLRS;
   localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic                  tready_q, tready_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]         data_q, data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  hs;

   function automatic logic [DW-1:0] clip_lanes(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
`ifdef POLAR_LLR_CLIP_EN
      for (int i = 0; i < BUS_LLRS; i++) begin
         if (d[i*LLR_WIDTH +: LLR_WIDTH] == {1'b1, {(LLR_WIDTH-1){1'b0}}})
            r[i*LLR_WIDTH +: LLR_WIDTH] = {1'b1, {(LLR_WIDTH-2){1'b0}}, 1'b1};
      end
`endif
      return r;
   endfunction

   assign hs = bus.saxi_tvalid & tready_q;

   always_comb begin
      state_d = state_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.input_en) begin
               state_d = RECV;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         RECV: begin
            // Losing input_en mid-frame is an abort, even if a beat is offered this cycle.
            if (!bus.input_en) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (hs) begin
               wr_en_d = 1'b1;
               addr_d  = cnt_q[ADDR_WIDTH-1:0];
               data_d  = clip_lanes(bus.saxi_tdata);
               cnt_d   = cnt_q + 1'b1;
               if (bus.saxi_tlast) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  if (cnt_q != LAST_CNT)
                     err_d = 1'b1;
               end else if (cnt_q == LAST_CNT) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!bus.input_en) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (hs && bus.saxi_tlast) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         DONE: begin
            if (!bus.input_en)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      tready_d = (state_d == RECV) || (state_d == DRAIN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tready_q <= 1'b0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tready_q <= tready_d;
         wr_en_q  <= wr_en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.saxi_tready   = tready_q;
   assign bus.llr_wr_en     = wr_en_q;
   assign bus.llr_wr_addr   = addr_q;
   assign bus.llr_wr_data   = data_q;
   assign bus.frame_done    = done_q;
   assign bus.frame_len_err = err_q;
   assign bus.beat_count    = cnt_q;
endmodule
